// File: rtl/sram_arb.sv
// rtl/sram_arb.sv - round-robin arbiter sharing one single-port SRAM port among NREQ requesters
// Supports a lock for atomic read-modify-write sequences and routes registered read data back to the issuer.
module sram_arb #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_cs,
  input  logic [NREQ-1:0]      req_lock,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW/8-1:0] req_byte,
  input  logic [NREQ*DW-1:0]   req_di,
  output logic [NREQ-1:0]      req_busy,
  output logic [NREQ-1:0]      req_rvld,
  output logic [DW-1:0]        req_do,
  output logic                 cs,
  output logic                 we,
  output logic [AW-1:0]        addr,
  output logic [DW/8-1:0]      byte_en,
  output logic [DW-1:0]        di,
  input  logic [DW-1:0]        do_data,
  input  logic                 busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = DW / 8;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            lk_vld_q, lk_vld_d;
  logic [PW-1:0]   lk_id_q, lk_id_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic [PW-1:0]   rsp_id_q, rsp_id_d;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_id;
  logic [NREQ-1:0] gnt;

  // Scan downward so the last hit written is the first requester at or after ptr.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (!busy) begin
      if (lk_vld_q) begin
        gnt_vld = req_cs[lk_id_q];
        gnt_id  = lk_id_q;
      end else begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (req_cs[PW'((int'(ptr_q) + k) % NREQ)]) begin
            gnt_vld = 1'b1;
            gnt_id  = PW'((int'(ptr_q) + k) % NREQ);
          end
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_vld) gnt[gnt_id] = 1'b1;
  end

  always_comb begin
    cs      = gnt_vld;
    we      = 1'b0;
    addr    = '0;
    byte_en = '0;
    di      = '0;
    if (gnt_vld) begin
      we      = req_we[gnt_id];
      addr    = req_addr[gnt_id*AW +: AW];
      byte_en = req_byte[gnt_id*BW +: BW];
      di      = req_di[gnt_id*DW +: DW];
    end
  end

  always_comb begin
    req_busy = req_cs & ~gnt;
    req_do   = do_data;
    req_rvld = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rvld[i] = rsp_vld_q && (rsp_id_q == PW'(i));
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    lk_vld_d  = lk_vld_q;
    lk_id_d   = lk_id_q;
    rsp_vld_d = 1'b0;
    rsp_id_d  = rsp_id_q;
    if (gnt_vld) begin
      ptr_d     = (gnt_id == PW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      lk_vld_d  = req_lock[gnt_id];
      lk_id_d   = gnt_id;
      rsp_vld_d = ~req_we[gnt_id];
      rsp_id_d  = gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q     <= '0;
      lk_vld_q  <= 1'b0;
      lk_id_q   <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
    end else begin
      ptr_q     <= ptr_d;
      lk_vld_q  <= lk_vld_d;
      lk_id_q   <= lk_id_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// tb/tb_sram_arb.sv - directed self-checking bench for sram_arb
// Two instances: NREQ=2 for most sequences, NREQ=4 for pointer wrap-around.
module tb_sram_arb;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [1:0]   a_cs, a_lock, a_we, a_busy, a_rvld;
  logic [63:0]  a_addr, a_di;
  logic [7:0]   a_byte;
  logic [31:0]  a_rdo, a_saddr, a_sdi, a_sdo;
  logic [3:0]   a_sbyte;
  logic         a_scs, a_swe, a_sbusy;

  logic [3:0]   b_cs, b_lock, b_we, b_busy, b_rvld;
  logic [127:0] b_addr, b_di;
  logic [15:0]  b_byte;
  logic [31:0]  b_rdo, b_saddr, b_sdi, b_sdo;
  logic [3:0]   b_sbyte;
  logic         b_scs, b_swe, b_sbusy;

  sram_arb #(.NREQ(2), .AW(32), .DW(32)) dut_a (
    .clk(clk), .rstn(rstn),
    .req_cs(a_cs), .req_lock(a_lock), .req_we(a_we), .req_addr(a_addr),
    .req_byte(a_byte), .req_di(a_di), .req_busy(a_busy), .req_rvld(a_rvld),
    .req_do(a_rdo), .cs(a_scs), .we(a_swe), .addr(a_saddr), .byte_en(a_sbyte),
    .di(a_sdi), .do_data(a_sdo), .busy(a_sbusy)
  );

  sram_arb #(.NREQ(4), .AW(32), .DW(32)) dut_b (
    .clk(clk), .rstn(rstn),
    .req_cs(b_cs), .req_lock(b_lock), .req_we(b_we), .req_addr(b_addr),
    .req_byte(b_byte), .req_di(b_di), .req_busy(b_busy), .req_rvld(b_rvld),
    .req_do(b_rdo), .cs(b_scs), .we(b_swe), .addr(b_saddr), .byte_en(b_sbyte),
    .di(b_sdi), .do_data(b_sdo), .busy(b_sbusy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    a_cs = '0; a_lock = '0; a_we = '0; a_addr = '0; a_byte = '0; a_di = '0;
    a_sdo = '0; a_sbusy = 1'b0;
    b_cs = '0; b_lock = '0; b_we = '0; b_addr = '0; b_byte = '0; b_di = '0;
    b_sdo = '0; b_sbusy = 1'b0;

    @(negedge clk); #1;
    chk("rst_cs", a_scs, 0);
    chk("rst_rvld", a_rvld, 0);
    chk("rst_ptr", dut_a.ptr_q, 0);
    chk("rst_lk", dut_a.lk_vld_q, 0);
    rstn = 1'b1;

    // single read
    @(negedge clk);
    a_cs = 2'b01; a_we = 2'b00; a_addr = {32'h0, 32'h40}; a_byte = 8'h0f;
    #1;
    chk("rd_cs", a_scs, 1);
    chk("rd_addr", a_saddr, 32'h40);
    chk("rd_we", a_swe, 0);
    chk("rd_byte", a_sbyte, 4'hf);
    chk("rd_busy", a_busy, 2'b00);
    @(negedge clk);
    a_cs = 2'b00; a_sdo = 32'hDEADBEEF;
    #1;
    chk("rd_rvld", a_rvld, 2'b01);
    chk("rd_do", a_rdo, 32'hDEADBEEF);
    chk("rd_idle_cs", a_scs, 0);

    @(negedge clk);
    rstn = 1'b0;
    #1;
    rstn = 1'b1;

    // round robin, both requesting
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a_cs = 2'b11; a_we = 2'b00; a_addr = {32'h20, 32'h10};
      #1;
      chk("rr_busy", a_busy, (c % 2 == 0) ? 2'b10 : 2'b01);
      chk("rr_addr", a_saddr, (c % 2 == 0) ? 32'h10 : 32'h20);
      if (c > 0) chk("rr_rvld", a_rvld, (c % 2 == 0) ? 2'b10 : 2'b01);
    end

    // lock: read-locked then write-unlock by req0, req1 waiting
    @(negedge clk);
    a_cs = 2'b11; a_lock = 2'b01; a_we = 2'b00; a_addr = {32'h200, 32'h100};
    #1;
    chk("lk_a_busy", a_busy, 2'b10);
    chk("lk_a_addr", a_saddr, 32'h100);
    chk("lk_a_rvld", a_rvld, 2'b10);
    @(negedge clk);
    a_lock = 2'b00; a_we = 2'b01; a_di = {32'h0, 32'h55};
    #1;
    chk("lk_b_busy", a_busy, 2'b10);
    chk("lk_b_we", a_swe, 1);
    chk("lk_b_di", a_sdi, 32'h55);
    chk("lk_b_rvld", a_rvld, 2'b01);
    @(negedge clk);
    a_cs = 2'b10; a_we = 2'b00;
    #1;
    chk("lk_c_lkvld", dut_a.lk_vld_q, 0);
    chk("lk_c_busy", a_busy, 2'b00);
    chk("lk_c_addr", a_saddr, 32'h200);
    chk("lk_c_rvld", a_rvld, 2'b00);

    // lock owner idle: req1 must still stall
    @(negedge clk);
    a_cs = 2'b11; a_lock = 2'b01;
    #1;
    chk("lk_d_busy", a_busy, 2'b10);
    @(negedge clk);
    a_cs = 2'b10;
    #1;
    chk("lk_e_cs", a_scs, 0);
    chk("lk_e_busy", a_busy, 2'b10);
    chk("lk_e_lkvld", dut_a.lk_vld_q, 1);
    chk("lk_e_rvld", a_rvld, 2'b01);
    @(negedge clk);
    a_cs = 2'b11; a_lock = 2'b00;
    #1;
    chk("lk_f_busy", a_busy, 2'b10);
    @(negedge clk);
    a_cs = 2'b10;
    #1;
    chk("lk_g_busy", a_busy, 2'b00);
    chk("lk_g_addr", a_saddr, 32'h200);
    chk("lk_g_rvld", a_rvld, 2'b01);
    @(negedge clk);
    a_cs = 2'b01;
    #1;
    chk("lk_h_busy", a_busy, 2'b00);
    chk("lk_h_rvld", a_rvld, 2'b10);

    // SRAM busy stall with ptr=1
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      a_cs = 2'b11; a_sbusy = 1'b1;
      #1;
      chk("bz_cs", a_scs, 0);
      chk("bz_busy", a_busy, 2'b11);
      chk("bz_ptr", dut_a.ptr_q, 1);
      chk("bz_rvld", a_rvld, (s == 0) ? 2'b01 : 2'b00);
    end
    @(negedge clk);
    a_sbusy = 1'b0; a_lock = 2'b10;
    #1;
    chk("bz_after_busy", a_busy, 2'b01);
    chk("bz_after_addr", a_saddr, 32'h200);

    // reset in the cycle after an accepted locked read
    @(negedge clk);
    rstn = 1'b0; a_cs = 2'b00; a_lock = 2'b00;
    #1;
    chk("mr_rvld", a_rvld, 2'b00);
    chk("mr_ptr", dut_a.ptr_q, 0);
    chk("mr_lk", dut_a.lk_vld_q, 0);
    rstn = 1'b1;
    @(negedge clk); #1;
    chk("mr_rvld2", a_rvld, 2'b00);

    // NREQ=4 wrap-around
    @(negedge clk);
    b_cs = 4'b0100; b_we = 4'b0000;
    b_addr = {32'h3000, 32'h2000, 32'h1000, 32'h0};
    #1;
    chk("wr_g2_busy", b_busy, 4'b0000);
    chk("wr_g2_addr", b_saddr, 32'h2000);
    @(negedge clk);
    b_cs = 4'b1010;
    #1;
    chk("wr_g3_busy", b_busy, 4'b0010);
    chk("wr_g3_addr", b_saddr, 32'h3000);
    chk("wr_g3_rvld", b_rvld, 4'b0100);
    @(negedge clk);
    b_cs = 4'b0010;
    #1;
    chk("wr_g1_busy", b_busy, 4'b0000);
    chk("wr_g1_addr", b_saddr, 32'h1000);
    chk("wr_g1_rvld", b_rvld, 4'b1000);
    @(negedge clk);
    b_cs = 4'b0000;
    #1;
    chk("wr_end_rvld", b_rvld, 4'b0010);
    chk("wr_end_cs", b_scs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
